sum_accum: RTL

SUM_ACCUM -- requirements
Module: sum_accum

---
 rtl/cla_pkg.sv | 16 +
 rtl/sum_accum_if.sv | 26 ++
 rtl/sum_accum_ctrl.sv | 82 ++++++++
 rtl/sum_accum.sv | 57 +++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the sum accumulator: FSM encoding and width helpers.
package cla_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned CNT_W   = 9;

    // Accumulator width that holds a full burst of (N+1)-bit sums without wrap.
    function automatic int unsigned acc_width(input int unsigned n, input int unsigned len);
        return n + 1 + $clog2(len);
    endfunction

endpackage

// File: rtl/sum_accum_if.sv
// Input/output handshake bundle between the adder stage, the accumulator and its consumer.
interface sum_accum_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned ACC_W = 11
);
    import cla_pkg::*;

    logic [N:0]       in_sum;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_sum, in_valid, flush, out_ready,
        input  in_ready, acc_out, out_count, out_valid
    );

    modport slave (
        input  in_sum, in_valid, flush, out_ready,
        output in_ready, acc_out, out_count, out_valid
    );
endinterface

// File: rtl/sum_accum_ctrl.sv
// Burst FSM and sample counter; tells the datapath when to load, add or clear.
module sum_accum_ctrl
    import cla_pkg::*;
#(
    parameter int unsigned LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             flush,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] cnt,
    output logic             acc_load_c,
    output logic             acc_add_c,
    output logic             acc_clr_c
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               accept;

    // in_ready is a registered copy of "not DONE", so accept needs no out_ready term
    assign accept = in_valid & in_ready;

    // State register; handshake flags are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_nxt;
            in_ready  <= (next_state != ST_DONE);
            out_valid <= (next_state == ST_DONE);
        end
    end

    // Next-state and datapath-control decode
    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        acc_load_c = 1'b0;
        acc_add_c  = 1'b0;
        acc_clr_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    acc_load_c = 1'b1;
                    cnt_nxt    = CNT_W'(1);
                    next_state = flush ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_add_c = 1'b1;
                    cnt_nxt   = cnt + CNT_W'(1);
                    if (flush || (cnt == CNT_W'(LEN - 1))) begin
                        next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    acc_clr_c  = 1'b1;
                    cnt_nxt    = '0;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                acc_clr_c  = 1'b1;
                cnt_nxt    = '0;
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/sum_accum.sv
// Accumulates bursts of LEN adder sums (or shorter, on flush) and hands the total downstream.
module sum_accum
    import cla_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned LEN   = 4,
    parameter int unsigned ACC_W = acc_width(N, LEN)
) (
    input  logic  clk,
    input  logic  reset,
    sum_accum_if.slave bus
);

    localparam int unsigned IN_W = N + 1;

    logic [IN_W-1:0]  sum_w;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             acc_load_c;
    logic             acc_add_c;
    logic             acc_clr_c;

    assign sum_w = bus.in_sum;

    sum_accum_ctrl #(
        .LEN (LEN)
    ) u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (bus.in_valid),
        .flush      (bus.flush),
        .out_ready  (bus.out_ready),
        .in_ready   (bus.in_ready),
        .out_valid  (bus.out_valid),
        .cnt        (cnt),
        .acc_load_c (acc_load_c),
        .acc_add_c  (acc_add_c),
        .acc_clr_c  (acc_clr_c)
    );

    // Accumulator register; unsigned zero-extended add, width chosen so it never wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (acc_clr_c) begin
            acc <= '0;
        end else if (acc_load_c) begin
            acc <= ACC_W'(sum_w);
        end else if (acc_add_c) begin
            acc <= acc + ACC_W'(sum_w);
        end
    end

    assign bus.acc_out   = acc;
    assign bus.out_count = cnt;

endmodule
